data_ram_responder: RTL and testbench
=====================================

// Module: data_ram_responder
// PURPOSE
// Memory-side responder for the CPU data-RAM port. Serves one read or write per
// request using the ram_read/ram_write/ram_addr strobes driven by the CPU. It
// holds a DEPTH x DATA_W register array and models WAIT_STATES access latency.
// A one-cycle ram_ack pulse completes each access and returns read data.
// PARAMETERS
// DATA_W       16  data word width
// ADDR_W       6   address width; DEPTH = 2**ADDR_W (64 words)
// WAIT_STATES  1   extra cycles spent in WAIT before RESP (0..15)
// PORTS
// clk          in   1       rising-edge clock
// reset        in   1       asynchronous, active-high reset
// ram_read     in   1       read request, held high by initiator until ram_ack
// ram_write    in   1       write request, held high by initiator until ram_ack
// ram_addr     in   ADDR_W  word address, sampled at request accept
// ram_wdata    in   DATA_W  write data, sampled at request accept (CPU ram_data_out)
// ram_rdata    out  DATA_W  read data, valid in the ram_ack cycle (CPU ram_data_in)
// ram_ack      out  1       one-cycle completion pulse for the accepted request
// ram_busy     out  1       high while a request is in flight (WAIT or RESP)
// ram_err      out  1       one-cycle pulse: ram_read and ram_write both high in IDLE
// BEHAVIOUR
// - Reset (async, reset=1): state=IDLE, counter=0, latched addr/data/op=0,
//   ram_rdata=0, ram_ack=0, ram_busy=0, ram_err=0, every array word=0.
//   Reset mid-access abandons it: no ack, no array write.
// - FSM states: IDLE, WAIT, RESP (registered; ram_busy = state!=IDLE).
// - IDLE: exactly one of ram_read/ram_write high -> latch op, ram_addr, ram_wdata;
//   load counter=WAIT_STATES; go WAIT (or RESP directly if WAIT_STATES==0).
//   Both high -> ram_err=1 next cycle, stay IDLE, nothing latched or written.
//   Neither high -> stay IDLE.
// - WAIT: counter decrements each cycle; at counter==1 go RESP. Inputs ignored.
// - RESP (one cycle): read -> ram_rdata <= mem[latched addr] and ram_ack=1 in
//   the same registered cycle; write -> mem[latched addr] <= latched data,
//   ram_ack=1, ram_rdata unchanged. Next state always IDLE.
// - Latency: accept at edge N -> ram_ack high in cycle N+1+WAIT_STATES.
// - ram_rdata holds its value between reads; changes only on a read ack.
// - Back-to-back: initiator drops strobe in ack cycle; a strobe still high in the
//   cycle after ack (IDLE) is a new request. Minimum request spacing 1+WAIT_STATES+1.
// - Request-line changes during WAIT/RESP have no effect (values latched).
// - Address wrap: none needed; ADDR_W bits cover full depth exactly.
// - Read-after-write same address: second request sees updated word (write is
//   complete at its ack edge).
// - ram_ack and ram_err are never high in the same cycle.
// TESTING
// - Reset, then read addr 6'd0 -> ram_ack after 2 cycles (WAIT_STATES=1), ram_rdata=16'h0000.
// - Write 16'hBEEF to 6'd63, then read 6'd63 -> ram_rdata=16'hBEEF at read ack; write ack
//   leaves ram_rdata unchanged.
// - ram_read & ram_write both high in IDLE -> ram_err pulse 1 cycle, no ack, mem[addr] unchanged.
// - Change ram_addr/ram_wdata from 5 to 9 during WAIT of a write to addr 5 -> only word 5 written.
// - Assert reset during WAIT of a write of 16'h1234 to 6'd10 -> no ack; later read 6'd10 = 16'h0000.
// - Sweep WAIT_STATES=0 and 3: write/read 16'hA5A5 at 6'd17 -> ack at 1 and 4 cycles after accept.

Source files
------------

// File: rtl/data_ram_responder.sv
// Data-RAM responder: serves one CPU read or write per request from a register array,
// with a configurable number of wait states before the single-cycle ack.
module data_ram_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_read,
  input  logic              ram_write,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_rdata,
  output logic              ram_ack,
  output logic              ram_busy,
  output logic              ram_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [3:0]        count_q;
  logic              op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  assign ram_busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ram_rdata  <= '0;
      ram_ack    <= 1'b0;
      ram_err    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ram_ack <= 1'b0;
      ram_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Conflicting strobes are flagged and dropped; nothing is latched.
          if (ram_read && ram_write) begin
            ram_err <= 1'b1;
          end else if (ram_read || ram_write) begin
            op_write_q <= ram_write;
            addr_q     <= ram_addr;
            wdata_q    <= ram_wdata;
            count_q    <= 4'(WAIT_STATES);
            state_q    <= (WAIT_STATES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (op_write_q) begin
            mem[addr_q] <= wdata_q;
          end else begin
            ram_rdata <= mem[addr_q];
          end
          ram_ack <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: three instances with WAIT_STATES of 1, 0 and 3
// share clock and reset; each scenario task checks its own expectations inline.
module tb_data_ram_responder;

  logic        clk;
  logic        reset;
  logic        rd    [3];
  logic        wr    [3];
  logic [5:0]  addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ack   [3];
  logic        busy  [3];
  logic        err   [3];

  int n_cmp;
  int n_fail;

  data_ram_responder #(.DATA_W(16), .ADDR_W(6), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .reset(reset), .ram_read(rd[0]), .ram_write(wr[0]), .ram_addr(addr[0]),
    .ram_wdata(wdata[0]), .ram_rdata(rdata[0]), .ram_ack(ack[0]), .ram_busy(busy[0]),
    .ram_err(err[0])
  );

  data_ram_responder #(.DATA_W(16), .ADDR_W(6), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(reset), .ram_read(rd[1]), .ram_write(wr[1]), .ram_addr(addr[1]),
    .ram_wdata(wdata[1]), .ram_rdata(rdata[1]), .ram_ack(ack[1]), .ram_busy(busy[1]),
    .ram_err(err[1])
  );

  data_ram_responder #(.DATA_W(16), .ADDR_W(6), .WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .reset(reset), .ram_read(rd[2]), .ram_write(wr[2]), .ram_addr(addr[2]),
    .ram_wdata(wdata[2]), .ram_rdata(rdata[2]), .ram_ack(ack[2]), .ram_busy(busy[2]),
    .ram_err(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered #1 after a rising edge. lat counts edges from accept to the ack cycle
  // (saturates at max_cyc when no ack arrives); busy_seen is busy just after accept.
  task automatic access(input int d, input bit is_wr, input logic [5:0] a,
                        input logic [15:0] wd, input int max_cyc, output int lat,
                        output logic [15:0] rdat, output logic busy_seen);
    rd[d] = !is_wr;
    wr[d] = is_wr;
    addr[d] = a;
    wdata[d] = wd;
    @(posedge clk); #1;
    busy_seen = busy[d];
    lat = 0;
    while (ack[d] !== 1'b1 && lat < max_cyc) begin
      @(posedge clk); #1;
      lat++;
    end
    rdat = rdata[d];
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack[0]); end
    n_cmp++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
    n_cmp++;
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err[0]); end
    n_cmp++;
    if (rdata[0] !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0000", rdata[0]);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_zero();
    int lat; logic [15:0] r; logic b;
    access(0, 1'b0, 6'd0, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("FAIL read0_latency: got %0d expected 2", lat); end
    n_cmp++;
    if (r !== 16'h0000) begin n_fail++; $display("FAIL read0_data: got %h expected 0000", r); end
    n_cmp++;
    if (b !== 1'b1) begin n_fail++; $display("FAIL read0_busy: got %b expected 1", b); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] r; logic b;
    access(0, 1'b1, 6'd63, 16'hBEEF, 10, lat, r, b);
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("FAIL wr63_latency: got %0d expected 2", lat); end
    n_cmp++;
    if (r !== 16'h0000) begin n_fail++; $display("FAIL wr63_rdata_hold: got %h expected 0000", r); end
    access(0, 1'b0, 6'd63, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (r !== 16'hBEEF) begin n_fail++; $display("FAIL rd63_data: got %h expected beef", r); end
    access(0, 1'b1, 6'd62, 16'h1111, 10, lat, r, b);
    n_cmp++;
    if (r !== 16'hBEEF) begin n_fail++; $display("FAIL wr62_rdata_hold: got %h expected beef", r); end
    access(0, 1'b0, 6'd62, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (r !== 16'h1111) begin n_fail++; $display("FAIL rd62_data: got %h expected 1111", r); end
  endtask

  task automatic test_conflict();
    int lat; logic [15:0] r; logic b;
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 6'd63; wdata[0] = 16'h0000;
    @(posedge clk); #1;
    rd[0] = 1'b0; wr[0] = 1'b0;
    n_cmp++;
    if (err[0] !== 1'b1) begin n_fail++; $display("FAIL conflict_err: got %b expected 1", err[0]); end
    n_cmp++;
    if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL conflict_ack: got %b expected 0", ack[0]); end
    n_cmp++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL conflict_busy: got %b expected 0", busy[0]); end
    @(posedge clk); #1;
    n_cmp++;
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL conflict_err_pulse: got %b expected 0", err[0]); end
    access(0, 1'b0, 6'd63, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (r !== 16'hBEEF) begin n_fail++; $display("FAIL conflict_mem: got %h expected beef", r); end
  endtask

  task automatic test_latch();
    int lat; logic [15:0] r; logic b;
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 6'd5; wdata[0] = 16'h5555;
    @(posedge clk); #1;
    addr[0] = 6'd9; wdata[0] = 16'h9999;
    lat = 0;
    while (ack[0] !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    wr[0] = 1'b0;
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("FAIL latch_latency: got %0d expected 2", lat); end
    access(0, 1'b0, 6'd5, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (r !== 16'h5555) begin n_fail++; $display("FAIL latch_word5: got %h expected 5555", r); end
    access(0, 1'b0, 6'd9, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (r !== 16'h0000) begin n_fail++; $display("FAIL latch_word9: got %h expected 0000", r); end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [15:0] r; logic b;
    wr[0] = 1'b1; addr[0] = 6'd10; wdata[0] = 16'h1234;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy[0]); end
    @(posedge clk); #1;
    n_cmp++;
    if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_ack: got %b expected 0", ack[0]); end
    wr[0] = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_ack_late: got %b expected 0", ack[0]); end
    access(0, 1'b0, 6'd10, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (r !== 16'h0000) begin n_fail++; $display("FAIL midrst_word10: got %h expected 0000", r); end
    access(0, 1'b0, 6'd63, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (r !== 16'h0000) begin n_fail++; $display("FAIL midrst_word63: got %h expected 0000", r); end
  endtask

  task automatic test_wait_sweep();
    int lat; logic [15:0] r; logic b;
    access(1, 1'b1, 6'd17, 16'hA5A5, 10, lat, r, b);
    n_cmp++;
    if (lat != 1) begin n_fail++; $display("FAIL ws0_wr_latency: got %0d expected 1", lat); end
    n_cmp++;
    if (b !== 1'b1) begin n_fail++; $display("FAIL ws0_busy: got %b expected 1", b); end
    access(1, 1'b0, 6'd17, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (lat != 1) begin n_fail++; $display("FAIL ws0_rd_latency: got %0d expected 1", lat); end
    n_cmp++;
    if (r !== 16'hA5A5) begin n_fail++; $display("FAIL ws0_rd_data: got %h expected a5a5", r); end
    access(2, 1'b1, 6'd17, 16'hA5A5, 10, lat, r, b);
    n_cmp++;
    if (lat != 4) begin n_fail++; $display("FAIL ws3_wr_latency: got %0d expected 4", lat); end
    access(2, 1'b0, 6'd17, 16'h0, 10, lat, r, b);
    n_cmp++;
    if (lat != 4) begin n_fail++; $display("FAIL ws3_rd_latency: got %0d expected 4", lat); end
    n_cmp++;
    if (r !== 16'hA5A5) begin n_fail++; $display("FAIL ws3_rd_data: got %h expected a5a5", r); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    test_reset();
    test_read_zero();
    test_back_to_back();
    test_conflict();
    test_latch();
    test_reset_mid_access();
    test_wait_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
